// File: rtl/usart_tx_fifo.sv
// -----------------------------------------------------------------------------
// usart_tx_fifo
//   Serial transmitter with a small transmit FIFO. Words pushed by the host are
//   sent back-to-back on tx_pin as: start bit, LSB-first data, optional parity,
//   then one or two stop bits. Frame format and bit period are latched when a
//   word leaves the FIFO (the bit period is also re-sampled at each bit boundary).
//
// Ports
//   serial_clock    sole clock, rising edge
//   reset_n         asynchronous active-low reset
//   clocks_per_bit  bit period minus one, in serial_clock cycles
//   parity_mode     00 none, 01 even, 10 odd, 11 none
//   two_stop_bits   1 = two stop bits, 0 = one stop bit
//   data_in         word to enqueue
//   latch_in        enqueue strobe
//   ready           FIFO can accept a word
//   done            one-cycle pulse at the end of each frame
//   busy            transmitter FSM not idle
//   fifo_count      words queued, excluding the word in flight
//   tx_pin          serial output, idles high
// -----------------------------------------------------------------------------
module usart_tx_fifo #(
   parameter int DATA_BITS     = 8,
   parameter int FIFO_DEPTH    = 4,
   parameter int DIVIDER_WIDTH = 12
) (
   input  logic                          serial_clock,
   input  logic                          reset_n,
   input  logic [DIVIDER_WIDTH-1:0]      clocks_per_bit,
   input  logic [1:0]                    parity_mode,
   input  logic                          two_stop_bits,
   input  logic [DATA_BITS-1:0]          data_in,
   input  logic                          latch_in,
   output logic                          ready,
   output logic                          done,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          tx_pin
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   // FIFO storage and bookkeeping
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;

   // Transmitter state
   logic [2:0]               state_q, state_d;
   logic [DIVIDER_WIDTH-1:0] baud_q, baud_d;
   logic [BW-1:0]            bit_q, bit_d;
   logic                     stop2_q, stop2_d;
   logic [DATA_BITS-1:0]     shift_q, shift_d;
   logic                     par_en_q, par_en_d;
   logic                     par_bit_q, par_bit_d;
   logic                     two_stop_q, two_stop_d;
   logic                     tx_q, tx_d;
   logic                     done_q, done_d;
   logic                     busy_q;

   logic                     push;
   logic                     pop;
   logic                     bit_end;
   logic [DATA_BITS-1:0]     head;

   // ready comes from the registered count only: a full FIFO refuses a push
   // even when a pop happens in the same cycle.
   assign ready   = (count_q < CW'(FIFO_DEPTH));
   assign push    = latch_in && ready;
   assign head    = mem_q[rd_ptr_q];
   assign bit_end = (baud_q == '0);

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      stop2_d    = stop2_q;
      shift_d    = shift_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      two_stop_d = two_stop_q;
      tx_d       = tx_q;
      done_d     = 1'b0;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
               bit_d   = '0;
               baud_d  = clocks_per_bit;
            end else begin
               baud_d = baud_q - DIVIDER_WIDTH'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_d = clocks_per_bit;
               if (bit_q == BW'(DATA_BITS - 1)) begin
                  if (par_en_q) begin
                     state_d = S_PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                     stop2_d = 1'b0;
                  end
               end else begin
                  // tx follows bit 1 of the old shift value, i.e. the new LSB
                  shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + BW'(1);
               end
            end else begin
               baud_d = baud_q - DIVIDER_WIDTH'(1);
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
               stop2_d = 1'b0;
               baud_d  = clocks_per_bit;
            end else begin
               baud_d = baud_q - DIVIDER_WIDTH'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (two_stop_q && !stop2_q) begin
                  stop2_d = 1'b1;
                  baud_d  = clocks_per_bit;
               end else begin
                  done_d = 1'b1;
                  if (count_q != '0) begin
                     // next word starts with no idle gap
                     pop = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     tx_d    = 1'b1;
                  end
               end
            end else begin
               baud_d = baud_q - DIVIDER_WIDTH'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // A pop always begins a new frame and freezes its format.
      if (pop) begin
         state_d    = S_START;
         tx_d       = 1'b0;
         baud_d     = clocks_per_bit;
         shift_d    = head;
         par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
         par_bit_d  = (^head) ^ (parity_mode == 2'b10);
         two_stop_d = two_stop_bits;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge serial_clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   always_ff @(posedge serial_clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         stop2_q    <= 1'b0;
         shift_q    <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         stop2_q    <= stop2_d;
         shift_q    <= shift_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         two_stop_q <= two_stop_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
         busy_q     <= (state_d != S_IDLE);
      end
   end

   assign tx_pin     = tx_q;
   assign done       = done_q;
   assign busy       = busy_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_usart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_usart_tx_fifo
//   Bench for usart_tx_fifo. Instance A uses 8 data bits, instance B uses 7.
//   Expected frames for A are queued when words are pushed; a receiver process
//   pops them when a start bit appears and compares every serial cycle.
// -----------------------------------------------------------------------------
module tb_usart_tx_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A (8 data bits)
   logic        rst_n_a;
   logic [11:0] cpb_a;
   logic [1:0]  pm_a;
   logic        ts_a;
   logic [7:0]  data_a;
   logic        latch_a;
   logic        ready_a, done_a, busy_a, tx_a;
   logic [2:0]  cnt_a;

   // Instance B (7 data bits)
   logic        rst_n_b;
   logic [11:0] cpb_b;
   logic [1:0]  pm_b;
   logic        ts_b;
   logic [6:0]  data_b;
   logic        latch_b;
   logic        ready_b, done_b, busy_b, tx_b;
   logic [2:0]  cnt_b;

   usart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIVIDER_WIDTH(12)) dut_a (
      .serial_clock(clk), .reset_n(rst_n_a), .clocks_per_bit(cpb_a),
      .parity_mode(pm_a), .two_stop_bits(ts_a), .data_in(data_a),
      .latch_in(latch_a), .ready(ready_a), .done(done_a), .busy(busy_a),
      .fifo_count(cnt_a), .tx_pin(tx_a));

   usart_tx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(4), .DIVIDER_WIDTH(12)) dut_b (
      .serial_clock(clk), .reset_n(rst_n_b), .clocks_per_bit(cpb_b),
      .parity_mode(pm_b), .two_stop_bits(ts_b), .data_in(data_b),
      .latch_in(latch_b), .ready(ready_b), .done(done_b), .busy(busy_b),
      .fifo_count(cnt_b), .tx_pin(tx_b));

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [8:0] data;
      int         nb;
      int         cpb0;   // bit period-1 for bits 0..sw
      int         cpb1;   // bit period-1 for bits after sw
      int         sw;
      logic [1:0] pm;
      logic       ts;
   } frame_t;

   typedef struct {
      logic [7:0]  data;
      logic [11:0] cpb;
      logic [1:0]  pm;
      logic        ts;
      logic        exp_par;
      int          exp_len;
   } vec_t;

   frame_t sb[$];

   int   rx_frames = 0;
   int   b2b       = 0;
   int   last_len  = 0;
   logic last_par  = 1'b0;
   int   done_cnt_a = 0;

   always @(negedge clk) begin
      if (done_a === 1'b1) done_cnt_a++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference serial image of one frame.
   task automatic build(input frame_t f, output int n, output logic b [0:15]);
      int ones;
      for (int i = 0; i < 16; i++) b[i] = 1'b1;
      ones = 0;
      b[0] = 1'b0;
      n = 1;
      for (int i = 0; i < f.nb; i++) begin
         b[n] = f.data[i];
         if (f.data[i]) ones++;
         n++;
      end
      if (f.pm == 2'b01) begin
         b[n] = (ones % 2) == 1;
         n++;
      end else if (f.pm == 2'b10) begin
         b[n] = (ones % 2) == 0;
         n++;
      end
      b[n] = 1'b1;
      n++;
      if (f.ts) begin
         b[n] = 1'b1;
         n++;
      end
   endtask

   task automatic expect_a(input logic [7:0] d, input int c0, input int c1, input int sw,
                           input logic [1:0] pm, input logic ts);
      frame_t f;
      f.data = {1'b0, d};
      f.nb   = 8;
      f.cpb0 = c0;
      f.cpb1 = c1;
      f.sw   = sw;
      f.pm   = pm;
      f.ts   = ts;
      sb.push_back(f);
   endtask

   // Called at a negedge; returns at the negedge after the push edge.
   task automatic push_a(input logic [7:0] d);
      data_a  = d;
      latch_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      latch_a = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget, input string name);
      int t;
      t = 0;
      while (rx_frames < target && t < budget) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk(name, rx_frames, target);
   endtask

   // Receiver / scoreboard for instance A
   initial begin : rx
      frame_t f;
      int     n, c, len, bad;
      logic   bits [0:15];
      bit     ab, nw;
      nw = 1'b1;
      forever begin
         if (nw) @(negedge clk);
         nw = 1'b1;
         if (rst_n_a === 1'b1 && tx_a === 1'b0) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rx_unexpected_start: tx low at %0t, expected idle", $time);
               while (tx_a === 1'b0 && rst_n_a === 1'b1) @(negedge clk);
            end else begin
               f = sb.pop_front();
               build(f, n, bits);
               len = 0;
               bad = 0;
               ab  = 1'b0;
               for (int j = 0; j < n && !ab; j++) begin
                  c = (j <= f.sw) ? f.cpb0 : f.cpb1;
                  for (int k = 0; k <= c && !ab; k++) begin
                     if (j != 0 || k != 0) @(negedge clk);
                     if (rst_n_a !== 1'b1) begin
                        ab = 1'b1;
                     end else begin
                        len++;
                        if (tx_a !== bits[j]) bad++;
                        if (!(j == 0 && k == 0) && done_a !== 1'b0) bad++;
                        if (k == 0 && j == f.nb + 1 && (f.pm == 2'b01 || f.pm == 2'b10))
                           last_par = tx_a;
                     end
                  end
               end
               if (!ab) begin
                  @(negedge clk);
                  if (rst_n_a === 1'b1) begin
                     chk("rx_frame_bits", bad, 0);
                     chk("rx_done_pulse", {31'd0, done_a}, 1);
                     last_len = len;
                     rx_frames++;
                     if (tx_a === 1'b0) begin
                        b2b++;
                        nw = 1'b0;
                     end
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: time limit reached, got %0d frames", rx_frames);
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

   initial begin : main
      vec_t   vt [6];
      frame_t fb;
      logic   bb [0:15];
      int     nb, bad, base, b0, dc, txlow;
      logic   pb;

      vt[0] = '{8'hAA, 12'd0, 2'b00, 1'b0, 1'b0, 10};
      vt[1] = '{8'h07, 12'd3, 2'b01, 1'b0, 1'b1, 44};
      vt[2] = '{8'h00, 12'd1, 2'b10, 1'b1, 1'b1, 24};
      vt[3] = '{8'hFF, 12'd0, 2'b01, 1'b0, 1'b0, 11};
      vt[4] = '{8'h5A, 12'd2, 2'b11, 1'b1, 1'b0, 33};
      vt[5] = '{8'h81, 12'd0, 2'b10, 1'b0, 1'b1, 11};

      rst_n_a = 1'b0; cpb_a = '0; pm_a = '0; ts_a = 1'b0; data_a = '0; latch_a = 1'b0;
      rst_n_b = 1'b0; cpb_b = '0; pm_b = '0; ts_b = 1'b0; data_b = '0; latch_b = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_tx_a", {31'd0, tx_a}, 1);
      chk("rst_ready_a", {31'd0, ready_a}, 1);
      chk("rst_done_a", {31'd0, done_a}, 0);
      chk("rst_busy_a", {31'd0, busy_a}, 0);
      chk("rst_cnt_a", {29'd0, cnt_a}, 0);
      chk("rst_tx_b", {31'd0, tx_b}, 1);
      chk("rst_ready_b", {31'd0, ready_b}, 1);
      chk("rst_cnt_b", {29'd0, cnt_b}, 0);
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;
      @(negedge clk);

      // First-push latency, 8N1, 1 cycle/bit
      expect_a(8'hAA, 0, 0, 99, 2'b00, 1'b0);
      push_a(8'hAA);
      chk("lat_tx_still_idle", {31'd0, tx_a}, 1);
      chk("lat_cnt_one", {29'd0, cnt_a}, 1);
      @(negedge clk);
      chk("lat_tx_start", {31'd0, tx_a}, 0);
      chk("lat_cnt_popped", {29'd0, cnt_a}, 0);
      chk("lat_busy", {31'd0, busy_a}, 1);
      wait_frames(1, 100, "lat_frame_seen");
      chk("lat_len", last_len, 10);
      @(negedge clk);
      chk("lat_busy_low", {31'd0, busy_a}, 0);
      chk("lat_done_low", {31'd0, done_a}, 0);

      // Frame-format vectors
      for (int i = 0; i < 6; i++) begin
         cpb_a = vt[i].cpb;
         pm_a  = vt[i].pm;
         ts_a  = vt[i].ts;
         base  = rx_frames;
         expect_a(vt[i].data, int'(vt[i].cpb), int'(vt[i].cpb), 99, vt[i].pm, vt[i].ts);
         push_a(vt[i].data);
         wait_frames(base + 1, 400, $sformatf("vec%0d_frame_seen", i));
         chk($sformatf("vec%0d_len", i), last_len, vt[i].exp_len);
         if (vt[i].pm == 2'b01 || vt[i].pm == 2'b10)
            chk($sformatf("vec%0d_parity", i), {31'd0, last_par}, {31'd0, vt[i].exp_par});
         @(negedge clk);
         chk($sformatf("vec%0d_busy_low", i), {31'd0, busy_a}, 0);
         chk($sformatf("vec%0d_done_low", i), {31'd0, done_a}, 0);
      end

      // 7 data bits, odd parity, two stop bits, 2 cycles/bit
      cpb_b = 12'd1; pm_b = 2'b10; ts_b = 1'b1;
      data_b = 7'h55; latch_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      latch_b = 1'b0;
      chk("b_idle_before_start", {31'd0, tx_b}, 1);
      fb.data = 9'h055; fb.nb = 7; fb.cpb0 = 1; fb.cpb1 = 1; fb.sw = 99; fb.pm = 2'b10; fb.ts = 1'b1;
      build(fb, nb, bb);
      bad = 0;
      pb  = 1'b0;
      for (int j = 0; j < nb; j++) begin
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (tx_b !== bb[j] || done_b !== 1'b0) bad++;
            if (j == 8 && k == 0) pb = tx_b;
         end
      end
      chk("b_frame_bits", bad, 0);
      chk("b_parity_bit", {31'd0, pb}, 1);
      @(negedge clk);
      chk("b_done_pulse", {31'd0, done_b}, 1);
      @(negedge clk);
      chk("b_done_single", {31'd0, done_b}, 0);
      chk("b_busy_low", {31'd0, busy_b}, 0);

      // Latch held six cycles: fill to depth, drop the sixth word
      cpb_a = 12'd0; pm_a = 2'b00; ts_a = 1'b0;
      base = rx_frames;
      b0   = b2b;
      dc   = done_cnt_a;
      for (int i = 1; i <= 6; i++) begin
         data_a  = 8'(i);
         latch_a = 1'b1;
         if (i <= 5) expect_a(8'(i), 0, 0, 99, 2'b00, 1'b0);
         if (i == 2) chk("fill_cnt_after_first", {29'd0, cnt_a}, 1);
         if (i == 5) chk("fill_ready_at_three", {31'd0, ready_a}, 1);
         if (i == 6) begin
            chk("fill_ready_low", {31'd0, ready_a}, 0);
            chk("fill_cnt_full", {29'd0, cnt_a}, 4);
         end
         @(posedge clk);
         @(negedge clk);
      end
      latch_a = 1'b0;
      wait_frames(base + 5, 300, "fill_frames_seen");
      chk("fill_back_to_back", b2b - b0, 4);
      chk("fill_done_pulses", done_cnt_a - dc, 5);
      repeat (3) @(negedge clk);
      chk("fill_no_sixth", {31'd0, busy_a}, 0);

      // Asynchronous reset during data bit 3 with two words queued
      cpb_a = 12'd3;
      expect_a(8'hC3, 3, 3, 99, 2'b00, 1'b0);
      push_a(8'hC3);
      expect_a(8'h11, 3, 3, 99, 2'b00, 1'b0);
      push_a(8'h11);
      expect_a(8'h22, 3, 3, 99, 2'b00, 1'b0);
      push_a(8'h22);
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("rst_mid_cnt_before", {29'd0, cnt_a}, 2);
      chk("rst_mid_bit3_before", {31'd0, tx_a}, 0);
      #1;
      rst_n_a = 1'b0;
      sb.delete();
      dc = done_cnt_a;
      #1;
      chk("rst_mid_tx", {31'd0, tx_a}, 1);
      chk("rst_mid_ready", {31'd0, ready_a}, 1);
      chk("rst_mid_cnt", {29'd0, cnt_a}, 0);
      chk("rst_mid_busy", {31'd0, busy_a}, 0);
      chk("rst_mid_done", {31'd0, done_a}, 0);
      repeat (3) @(negedge clk);
      rst_n_a = 1'b1;
      txlow = 0;
      repeat (30) begin
         @(negedge clk);
         if (tx_a !== 1'b1) txlow++;
      end
      chk("rst_mid_tx_stays_high", txlow, 0);
      chk("rst_mid_no_done", done_cnt_a - dc, 0);
      chk("rst_mid_busy_after", {31'd0, busy_a}, 0);

      // Mid-frame format change
      cpb_a = 12'd1; pm_a = 2'b01; ts_a = 1'b0;
      base = rx_frames;
      b0   = b2b;
      expect_a(8'h01, 1, 2, 3, 2'b01, 1'b0);
      push_a(8'h01);
      repeat (7) @(posedge clk);
      @(negedge clk);
      cpb_a = 12'd2;
      pm_a  = 2'b10;
      expect_a(8'h07, 2, 2, 99, 2'b10, 1'b0);
      push_a(8'h07);
      wait_frames(base + 1, 200, "chg_first_seen");
      chk("chg_first_len", last_len, 29);
      chk("chg_first_parity_even", {31'd0, last_par}, 1);
      wait_frames(base + 2, 200, "chg_second_seen");
      chk("chg_second_len", last_len, 33);
      chk("chg_second_parity_odd", {31'd0, last_par}, 0);
      chk("chg_back_to_back", b2b - b0, 1);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
